// File: rtl/ray_step_ctrl.sv
// ray_step_ctrl -- sphere-tracing step controller.
//
// Accepts one ray at a time, sends sample points to an external SDF stage
// and marches along the ray by each returned distance. The march ends on a
// surface hit, an escape past MAX_DIST, or after MAX_STEPS evaluations.
// The result is then held until it is consumed.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   ray_origin    ray start point (vec3, Q16.16)
//   ray_dir       unit direction (vec3, Q16.16)
//   ray_valid     new ray offered
//   ray_ready     controller is idle and accepting a ray
//   point_out     current sample point sent to the SDF stage
//   point_valid   one-cycle request strobe for point_out
//   sdf_in        distance returned by the SDF stage
//   sdf_valid     sdf_in is valid (only honoured while waiting)
//   res_hit       1 = surface hit, 0 = miss
//   res_t         accumulated distance along the ray
//   res_point     final march point
//   res_steps     number of SDF evaluations used
//   res_valid     result available, held until res_ready
//   res_ready     result consumer ready

package vector_pkg;
    typedef logic signed [31:0] fp;
    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;
endpackage

module ray_step_ctrl
    import vector_pkg::*;
#(
    parameter int unsigned MAX_STEPS = 64,
    parameter fp           EPS       = 32'h0000_0041,
    parameter fp           MAX_DIST  = 32'h0064_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  vec3        ray_origin,
    input  vec3        ray_dir,
    input  logic       ray_valid,
    output logic       ray_ready,
    output vec3        point_out,
    output logic       point_valid,
    input  fp          sdf_in,
    input  logic       sdf_valid,
    output logic       res_hit,
    output fp          res_t,
    output vec3        res_point,
    output logic [7:0] res_steps,
    output logic       res_valid,
    input  logic       res_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t     state;
    vec3        point;
    vec3        dir;
    fp          t;
    logic [7:0] steps;

    // Datapath for one march step, evaluated against the returned distance.
    logic       is_hit;
    logic       escaped;
    logic       last_step;
    logic [7:0] steps_next;
    logic [32:0] t_sum;
    fp          t_next;
    vec3        point_next;

    // Q16.16 multiply: full 64-bit signed product, arithmetic shift by 16,
    // keep the low 32 bits (wraps on overflow).
    function automatic fp fx_mul(input fp a, input fp b);
        logic signed [63:0] pa;
        logic signed [63:0] pb;
        pa = {{32{a[31]}}, a};
        pb = {{32{b[31]}}, b};
        return fp'((pa * pb) >>> 16);
    endfunction

    always_comb begin
        is_hit     = (sdf_in < EPS);
        steps_next = steps + 8'd1;
        // t is never negative and sdf_in >= EPS whenever t advances, so a set
        // bit 31 in the unsigned sum means the signed result overflowed.
        t_sum      = {1'b0, t} + {1'b0, sdf_in};
        t_next     = t_sum[31] ? fp'(32'h7FFF_FFFF) : fp'(t_sum[31:0]);
        point_next.x = point.x + fx_mul(dir.x, sdf_in);
        point_next.y = point.y + fx_mul(dir.y, sdf_in);
        point_next.z = point.z + fx_mul(dir.z, sdf_in);
        escaped    = (t_next > MAX_DIST);
        last_step  = (steps_next == 8'(MAX_STEPS));
    end

    assign point_out = point;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ray_ready   <= 1'b0;
            point_valid <= 1'b0;
            point       <= '0;
            dir         <= '0;
            t           <= '0;
            steps       <= '0;
            res_hit     <= 1'b0;
            res_t       <= '0;
            res_point   <= '0;
            res_steps   <= '0;
            res_valid   <= 1'b0;
        end else begin
            point_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // ray_ready is registered, so it rises one clock after
                    // reset release and after a result handshake.
                    ray_ready <= 1'b1;
                    if (ray_ready && ray_valid) begin
                        ray_ready   <= 1'b0;
                        point       <= ray_origin;
                        dir         <= ray_dir;
                        t           <= '0;
                        steps       <= '0;
                        point_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (sdf_valid) begin
                        steps <= steps_next;
                        if (is_hit) begin
                            res_hit   <= 1'b1;
                            res_t     <= t;
                            res_point <= point;
                            res_steps <= steps_next;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            t     <= t_next;
                            point <= point_next;
                            if (escaped || last_step) begin
                                res_hit   <= 1'b0;
                                res_t     <= t_next;
                                res_point <= point_next;
                                res_steps <= steps_next;
                                res_valid <= 1'b1;
                                state     <= DONE;
                            end else begin
                                point_valid <= 1'b1;
                                state       <= ISSUE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ray_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ray_step_ctrl.sv
// Testbench for ray_step_ctrl: directed rays against a 1-cycle SDF responder,
// expected results queued by the stimulus and compared by a monitor on each
// result handshake.

module tb_ray_step_ctrl;
    import vector_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    vec3        ray_origin;
    vec3        ray_dir;
    logic       ray_valid;
    logic       ray_ready;
    vec3        point_out;
    logic       point_valid;
    fp          sdf_in;
    logic       sdf_valid;
    logic       res_hit;
    fp          res_t;
    vec3        res_point;
    logic [7:0] res_steps;
    logic       res_valid;
    logic       res_ready;

    ray_step_ctrl #(
        .MAX_STEPS (64),
        .EPS       (32'h0000_0041),
        .MAX_DIST  (32'h0064_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ray_origin  (ray_origin),
        .ray_dir     (ray_dir),
        .ray_valid   (ray_valid),
        .ray_ready   (ray_ready),
        .point_out   (point_out),
        .point_valid (point_valid),
        .sdf_in      (sdf_in),
        .sdf_valid   (sdf_valid),
        .res_hit     (res_hit),
        .res_t       (res_t),
        .res_point   (res_point),
        .res_steps   (res_steps),
        .res_valid   (res_valid),
        .res_ready   (res_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       hit;
        fp          t;
        vec3        pt;
        logic [7:0] steps;
    } res_exp_t;

    res_exp_t exp_q[$];
    res_exp_t mon_e;
    int       errors = 0;
    int       checks = 0;
    int       pv_count = 0;

    fp    sdf_script[$];
    fp    sdf_const = '0;
    logic sdf_en = 1'b1;
    logic manual_pulse = 1'b0;

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    // SDF model: answers each point_valid one cycle later.
    initial sdf_in = '0;
    always @(posedge clk) begin
        sdf_valid <= 1'b0;
        if (manual_pulse) begin
            sdf_valid <= 1'b1;
            sdf_in    <= 32'h0001_0000;
        end else if (point_valid && sdf_en) begin
            sdf_valid <= 1'b1;
            if (sdf_script.size() > 0) sdf_in <= sdf_script.pop_front();
            else                       sdf_in <= sdf_const;
        end
    end

    // Monitor: compares each consumed result with the oldest expectation.
    always @(negedge clk) begin
        if (point_valid) pv_count++;
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got hit=%0b t=%h required none", res_hit, res_t);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_hit",   res_hit,   mon_e.hit);
                check("res_t",     res_t,     mon_e.t);
                check("res_point", res_point, mon_e.pt);
                check("res_steps", res_steps, mon_e.steps);
            end
        end
    end

    task automatic run_ray(input vec3 org, input vec3 dir, input logic hit,
                           input fp t, input vec3 pt, input int steps,
                           input int hold_cycles);
        int   cyc;
        int   pvc;
        logic s_hit;
        fp    s_t;
        vec3  s_pt;
        logic [7:0] s_steps;
        exp_q.push_back('{hit, t, pt, 8'(steps)});
        cyc = 0;
        while (!ray_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check("ray_ready_before", ray_ready, 1'b1);
        ray_origin = org;
        ray_dir    = dir;
        ray_valid  = 1'b1;
        @(posedge clk); #1;
        ray_valid = 1'b0;
        cyc = 0;
        while (!res_valid && cyc < 400) begin
            @(posedge clk); #1; cyc++;
        end
        // Accept edge plus two cycles per SDF evaluation.
        check("latency", cyc, 2 * steps);
        if (!res_valid) begin
            void'(exp_q.pop_back());
            return;
        end
        s_hit = res_hit; s_t = res_t; s_pt = res_point; s_steps = res_steps;
        pvc = pv_count;
        for (int i = 0; i < hold_cycles; i++) begin
            ray_origin = '0;
            ray_valid  = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", res_valid, 1'b1);
            check("hold_ready", ray_ready, 1'b0);
            check("hold_res", {s_hit, s_t, s_pt, s_steps},
                  {res_hit, res_t, res_point, res_steps});
        end
        ray_valid = 1'b0;
        if (hold_cycles > 0) check("hold_no_issue", pv_count, pvc);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("res_valid_drop", res_valid, 1'b0);
        check("turnaround_ready", ray_ready, 1'b1);
    endtask

    initial begin
        int pvc;
        rst = 1'b1;
        ray_valid = 1'b0;
        res_ready = 1'b0;
        ray_origin = '0;
        ray_dir = '0;
        #2;
        check("rst_ray_ready",   ray_ready,   1'b0);
        check("rst_res_valid",   res_valid,   1'b0);
        check("rst_point_valid", point_valid, 1'b0);
        check("rst_res_t",       res_t,       32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("ready_before_clk", ray_ready, 1'b0);
        @(posedge clk); #1;
        check("ready_first_clk", ray_ready, 1'b1);

        // Hit: (0,0,-5) along +z, SDF 4.0 then 0.0.
        sdf_script = {32'h0004_0000, 32'h0000_0000};
        run_ray('{32'h0, 32'h0, 32'hFFFB_0000}, '{32'h0, 32'h0, 32'h0001_0000},
                1'b1, 32'h0004_0000, '{32'h0, 32'h0, 32'hFFFF_0000}, 2, 0);

        // Escape: SDF 10.0 forever; t = 100.0 exactly still continues.
        sdf_script = {};
        sdf_const  = 32'h000A_0000;
        run_ray('{32'h0, 32'h0, 32'h0}, '{32'h0001_0000, 32'h0, 32'h0},
                1'b0, 32'h006E_0000, '{32'h006E_0000, 32'h0, 32'h0}, 11, 0);

        // Step limit: SDF 0.5 forever.
        sdf_const = 32'h0000_8000;
        run_ray('{32'h0001_0000, 32'h0002_0000, 32'h0003_0000},
                '{32'h0, 32'h0001_0000, 32'h0},
                1'b0, 32'h0020_0000,
                '{32'h0001_0000, 32'h0022_0000, 32'h0003_0000}, 64, 0);

        // Inside on first sample: -0.25.
        sdf_script = {32'hFFFF_C000};
        run_ray('{32'h0003_0000, 32'hFFFE_0000, 32'h0007_0000},
                '{32'h0, 32'h0, 32'h0001_0000},
                1'b1, 32'h0, '{32'h0003_0000, 32'hFFFE_0000, 32'h0007_0000}, 1, 0);

        // EPS boundary: sdf == EPS advances, EPS-1 hits.
        sdf_script = {32'h0000_0041, 32'h0000_0040};
        run_ray('{32'h0, 32'h0, 32'h0}, '{32'h0, 32'h0, 32'h0001_0000},
                1'b1, 32'h0000_0041, '{32'h0, 32'h0, 32'h0000_0041}, 2, 0);

        // Fractional and negative direction components.
        sdf_script = {32'h0002_0000, 32'h0000_0000};
        run_ray('{32'h0, 32'h0, 32'h0}, '{32'h0000_8000, 32'hFFFF_8000, 32'h0000_C000},
                1'b1, 32'h0002_0000, '{32'h0001_0000, 32'hFFFF_0000, 32'h0001_8000}, 2, 0);

        // Backpressure: result held 10 cycles with a competing ray_valid.
        sdf_script = {32'h0004_0000, 32'h0000_0000};
        run_ray('{32'h0, 32'h0, 32'hFFFB_0000}, '{32'h0, 32'h0, 32'h0001_0000},
                1'b1, 32'h0004_0000, '{32'h0, 32'h0, 32'hFFFF_0000}, 2, 10);

        // Reset mid-WAIT with the SDF stage silent, then a late sdf_valid.
        sdf_en = 1'b0;
        ray_origin = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        ray_dir    = '{32'h0, 32'h0, 32'h0001_0000};
        ray_valid  = 1'b1;
        @(posedge clk); #1;
        ray_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_ray_ready",   ray_ready,   1'b0);
        check("midrst_point_valid", point_valid, 1'b0);
        check("midrst_res_valid",   res_valid,   1'b0);
        check("midrst_point_out",   point_out,   96'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        pvc = pv_count;
        sdf_en = 1'b1;
        manual_pulse = 1'b1;
        @(posedge clk); #1;
        manual_pulse = 1'b0;
        check("midrst_ready_first_clk", ray_ready, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("late_sdf_no_issue",  pv_count,  pvc);
        check("late_sdf_res_valid", res_valid, 1'b0);
        check("late_sdf_ray_ready", ray_ready, 1'b1);
        check("late_sdf_steps",     res_steps, 8'd0);

        check("exp_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ray_step_ctrl.md
RAY_STEP_CTRL -- requirements
Module: ray_step_ctrl

Interface
REQ-001 SHALL take parameter MAX_STEPS, default 64, meaning the maximum number of SDF evaluations per ray.
REQ-002 SHALL take parameter EPS (fp), default 32'h0000_0041 (~0.001), meaning the hit threshold.
REQ-003 SHALL take parameter MAX_DIST (fp), default 32'h0064_0000 (100.0), meaning the escape distance.
REQ-004 SHALL use fp = 32-bit signed Q16.16 and vec3 = {x,y,z} of fp, both from vector_pkg.
REQ-005 Clock and reset are decided: one clock; reset is asynchronous and active-high. Ports `clk  in  1  rising-edge clock` and `rst  in  1  asynchronous active-high reset`.
REQ-006 Port `ray_origin  in  vec3  ray start point`.
REQ-007 Port `ray_dir  in  vec3  unit direction`.
REQ-008 Port `ray_valid  in  1`.
REQ-009 Port `ray_ready  out  1  accepting a new ray`.
REQ-010 Port `point_out  out  vec3  sample point sent to SDF stage`.
REQ-011 Port `point_valid  out  1  one-cycle request strobe`.
REQ-012 Port `sdf_in  in  fp  distance from SDF stage`.
REQ-013 Port `sdf_valid  in  1`.
REQ-014 Port `res_hit  out  1  1=surface hit, 0=miss`.
REQ-015 Port `res_t  out  fp  accumulated distance`.
REQ-016 Port `res_point  out  vec3  final march point`.
REQ-017 Port `res_steps  out  8  SDF evaluations used`.
REQ-018 Port `res_valid  out  1`.
REQ-019 Port `res_ready  in  1`.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-021 IDLE: ray_ready=1. On ray_valid, SHALL latch origin/dir, set point=origin, t=0, steps=0, and go to ISSUE.
REQ-022 ISSUE: SHALL assert point_valid for exactly one cycle with point_out=current point, then go to WAIT.
REQ-023 WAIT: SHALL tolerate any SDF latency (nominal 1 cycle).
REQ-024 WAIT: on sdf_valid, SHALL set steps+=1 and evaluate in this priority:
  (a) sdf_in < EPS (signed compare; negative counts as inside) -> hit=1; t and point unchanged; go to DONE.
  (b) otherwise t+=sdf_in and point.c += (dir.c*sdf_in)>>>16 per component (64-bit product, arithmetic shift, truncate to 32 bits).
  (c) if new t > MAX_DIST -> hit=0; go to DONE.
  (d) else if steps == MAX_STEPS -> hit=0; go to DONE.
  (e) else go to ISSUE.
REQ-025 SHALL ignore sdf_valid in any state other than WAIT.
REQ-026 DONE: SHALL hold res_valid=1 and all res_* stable until res_ready=1; on res_valid&&res_ready, SHALL go to IDLE the next cycle.
REQ-027 ray_ready SHALL be 0 in ISSUE, WAIT and DONE; a ray_valid there is not accepted.
REQ-028 res_t, res_point and res_steps SHALL equal the internal t, point and steps at DONE entry.
REQ-029 Minimum ray-to-result latency at 1-cycle SDF SHALL be 1 + 2*steps cycles; result-to-next-ray turnaround SHALL be 1 idle cycle.
REQ-030 t addition SHALL saturate at 32'h7FFF_FFFF; point arithmetic wraps.

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE and zero res_*, point_out, t, and steps.
REQ-032 Under rst, point_valid and res_valid SHALL be 0 and ray_ready SHALL be 0.
REQ-033 ray_ready SHALL go to 1 on the first clock after rst deasserts.
REQ-034 Reset mid-ray SHALL abandon the ray; a late sdf_valid afterwards SHALL be ignored.

Verification
REQ-035 Hit: origin (0,0,-5.0), dir (0,0,1.0); SDF model returns 4.0 then 0.0 -> res_hit=1, res_t=4.0, res_point=(0,0,-1.0), res_steps=2.
REQ-036 Escape: SDF always 10.0 -> res_hit=0, res_steps=11, res_t=110.0.
REQ-037 Step limit: SDF always 0.5 -> res_hit=0, res_steps=64, res_t=32.0.
REQ-038 Inside: first SDF returns -0.25 -> res_hit=1, res_steps=1, res_t=0, res_point=origin.
REQ-039 Backpressure: hold res_ready=0 for 10 cycles in DONE -> res_* stable, ray_ready=0, and a new ray_valid is not accepted; then res_ready=1 -> IDLE one cycle later.
REQ-040 Reset mid-WAIT, then sdf_valid pulsed after rst drops -> no point_valid, res_valid=0, ray_ready=1.
